// File: rtl/ram_dual_port_resp.sv
// ram_dual_port_resp
//   Responder-side dual-port RAM (8 x 10 by default) for the memory tester.
//   Tracks which entries hold written data. Returns registered read data with
//   a valid strobe, and supports an optional destructive-read mode. Reports
//   read-of-empty errors and occupancy status.
//
// Ports
//   clk           in   single clock, rising edge
//   reset         in   synchronous, active-high reset
//   data_a        in   write data
//   addr_wa       in   write address
//   addr_ra       in   read address
//   we_a          in   write enable
//   re_a          in   read enable
//   state         in   4'd1 = destructive read, any other value = normal read
//   q_a           out  registered read data
//   valid_q       out  one-cycle pulse: q_a carries data from a written entry
//   err_rd_empty  out  one-cycle pulse: read targeted an invalid entry
//   occupancy     out  registered count of valid entries
//   full          out  occupancy == DEPTH
//   empty         out  occupancy == 0
module ram_dual_port_resp #(
  parameter int DATA_WIDTH = 10,
  parameter int ADDR_WIDTH = 3,
  parameter int DEPTH      = 1 << ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_a,
  input  logic [ADDR_WIDTH-1:0] addr_wa,
  input  logic [ADDR_WIDTH-1:0] addr_ra,
  input  logic                  we_a,
  input  logic                  re_a,
  input  logic [3:0]            state,
  output logic [DATA_WIDTH-1:0] q_a,
  output logic                  valid_q,
  output logic                  err_rd_empty,
  output logic [ADDR_WIDTH:0]   occupancy,
  output logic                  full,
  output logic                  empty
);

  localparam logic [3:0] MODE_DESTRUCTIVE = 4'd1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0]      valid_map_q, valid_map_d;
  logic [DATA_WIDTH-1:0] q_a_q, q_a_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  err_q, err_d;
  logic [ADDR_WIDTH:0]   occ_q, occ_d;

  // NOTE: every always_comb output gets a default on entry so no path leaves
  // it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    mem_d       = mem_q;
    valid_map_d = valid_map_q;
    q_a_d       = q_a_q;      // q_a holds its value when no read is issued
    rd_valid_d  = 1'b0;
    err_d       = 1'b0;

    if (re_a) begin
      if (we_a && (addr_wa == addr_ra)) begin
        // Write-first bypass: the incoming data is returned and the read is
        // never an error, whatever the entry held before.
        q_a_d      = data_a;
        rd_valid_d = 1'b1;
      end else if (valid_map_q[addr_ra]) begin
        q_a_d      = mem_q[addr_ra];
        rd_valid_d = 1'b1;
        if (state == MODE_DESTRUCTIVE) begin
          valid_map_d[addr_ra] = 1'b0;
        end
      end else begin
        q_a_d = '0;
        err_d = 1'b1;
      end
    end

    // Applied after the read so a same-address write overrides a destructive
    // clear and leaves the entry valid with the new data.
    if (we_a) begin
      mem_d[addr_wa]       = data_a;
      valid_map_d[addr_wa] = 1'b1;
    end

    occ_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occ_d = occ_d + (ADDR_WIDTH + 1)'(valid_map_d[i]);
    end
  end

  // NOTE: the storage array is cleared by reset here because the memory must
  // read back as zero after reset; a plain RAM array would normally stay
  // unreset so it can map onto block RAM.
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      valid_map_q <= '0;
      q_a_q       <= '0;
      rd_valid_q  <= 1'b0;
      err_q       <= 1'b0;
      occ_q       <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      valid_map_q <= valid_map_d;
      q_a_q       <= q_a_d;
      rd_valid_q  <= rd_valid_d;
      err_q       <= err_d;
      occ_q       <= occ_d;
    end
  end

  assign q_a          = q_a_q;
  assign valid_q      = rd_valid_q;
  assign err_rd_empty = err_q;
  assign occupancy    = occ_q;
  assign full         = (occ_q == (ADDR_WIDTH + 1)'(DEPTH));
  assign empty        = (occ_q == '0);

endmodule

// File: tb/tb_ram_dual_port_resp.sv
// tb_ram_dual_port_resp
//   Directed bench for ram_dual_port_resp. Each read request pushes its
//   hand-computed response into a queue; a monitor pops and compares whenever
//   the DUT presents valid_q or err_rd_empty. Status outputs are checked
//   directly after the edge that updates them.
module tb_ram_dual_port_resp;

  localparam int DW = 10;
  localparam int AW = 3;

  typedef struct packed {
    logic [DW-1:0] q;
    logic          v;
    logic          e;
  } resp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] data_a;
  logic [AW-1:0] addr_wa, addr_ra;
  logic          we_a, re_a;
  logic [3:0]    state;
  logic [DW-1:0] q_a;
  logic          valid_q, err_rd_empty;
  logic [AW:0]   occupancy;
  logic          full, empty;

  resp_t exp_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;

  ram_dual_port_resp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .data_a(data_a), .addr_wa(addr_wa),
    .addr_ra(addr_ra), .we_a(we_a), .re_a(re_a), .state(state),
    .q_a(q_a), .valid_q(valid_q), .err_rd_empty(err_rd_empty),
    .occupancy(occupancy), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock of stimulus: inputs applied now, sampled at the next edge,
  // task returns 1 time unit after that edge.
  task automatic cycle(input logic we, input logic [AW-1:0] wa,
                       input logic [DW-1:0] d, input logic re,
                       input logic [AW-1:0] ra, input logic [3:0] st);
    we_a = we; addr_wa = wa; data_a = d;
    re_a = re; addr_ra = ra; state = st;
    @(posedge clk); #1;
    we_a = 1'b0; re_a = 1'b0;
  endtask

  task automatic wr(input logic [AW-1:0] wa, input logic [DW-1:0] d);
    cycle(1'b1, wa, d, 1'b0, '0, 4'd0);
  endtask

  task automatic rd(input logic [AW-1:0] ra, input logic [3:0] st,
                    input logic [DW-1:0] eq, input logic ev, input logic ee);
    exp_q.push_back('{q: eq, v: ev, e: ee});
    cycle(1'b0, '0, '0, 1'b1, ra, st);
  endtask

  task automatic wr_rd(input logic [AW-1:0] wa, input logic [DW-1:0] d,
                       input logic [AW-1:0] ra, input logic [3:0] st,
                       input logic [DW-1:0] eq, input logic ev, input logic ee);
    exp_q.push_back('{q: eq, v: ev, e: ee});
    cycle(1'b1, wa, d, 1'b1, ra, st);
  endtask

  task automatic check_status(input string tag, input int occ);
    check({tag, " occupancy"}, 32'(occupancy), 32'(occ));
    check({tag, " full"},      32'(full),      32'(occ == 8));
    check({tag, " empty"},     32'(empty),     32'(occ == 0));
  endtask

  // Monitor: compare every presented response against the scoreboard.
  initial begin
    resp_t e;
    forever begin
      @(negedge clk);
      if (!reset && (valid_q || err_rd_empty)) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_resp: got q=0x%0h v=%0b e=%0b, expected none",
                   q_a, valid_q, err_rd_empty);
        end else begin
          e = exp_q.pop_front();
          check("resp q_a",          32'(q_a),          32'(e.q));
          check("resp valid_q",      32'(valid_q),      32'(e.v));
          check("resp err_rd_empty", 32'(err_rd_empty), 32'(e.e));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; we_a = 1'b0; re_a = 1'b0;
    data_a = '0; addr_wa = '0; addr_ra = '0; state = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst q_a",          32'(q_a),          32'd0);
    check("rst valid_q",      32'(valid_q),      32'd0);
    check("rst err_rd_empty", 32'(err_rd_empty), 32'd0);
    check_status("rst", 0);
    reset = 1'b0;

    // Read of a never-written entry.
    rd(3'd5, 4'd0, 10'h000, 1'b0, 1'b1);

    // Fill addr 0..3 and read them back-to-back.
    wr(3'd0, 10'b1111111111);
    wr(3'd1, 10'b1010101010);
    wr(3'd2, 10'b0101010101);
    wr(3'd3, 10'b1111100000);
    check_status("fill4", 4);
    rd(3'd0, 4'd0, 10'b1111111111, 1'b1, 1'b0);
    rd(3'd1, 4'd0, 10'b1010101010, 1'b1, 1'b0);
    rd(3'd2, 4'd0, 10'b0101010101, 1'b1, 1'b0);
    rd(3'd3, 4'd0, 10'b1111100000, 1'b1, 1'b0);
    check_status("reads4", 4);

    // Fill to 8, then overwrite addr 7.
    wr(3'd4, 10'h011);
    wr(3'd5, 10'h022);
    wr(3'd6, 10'h033);
    check_status("fill7", 7);
    wr(3'd7, 10'h044);
    check_status("fill8", 8);
    wr(3'd7, 10'b0000000100);
    check_status("rewrite7", 8);
    rd(3'd7, 4'd0, 10'b0000000100, 1'b1, 1'b0);

    // Destructive read of addr 1, then re-read is an error.
    rd(3'd1, 4'd1, 10'b1010101010, 1'b1, 1'b0);
    check_status("destr1", 7);
    rd(3'd1, 4'd1, 10'h000, 1'b0, 1'b1);
    check_status("destr1_again", 7);

    // Clear addr 6, then collide on it in destructive mode: write wins.
    rd(3'd6, 4'd1, 10'h033, 1'b1, 1'b0);
    check_status("destr6", 6);
    wr_rd(3'd6, 10'b0000000010, 3'd6, 4'd1, 10'b0000000010, 1'b1, 1'b0);
    check_status("collide6", 7);
    rd(3'd6, 4'd0, 10'b0000000010, 1'b1, 1'b0);

    // Write addr 1 while reading addr 0: both take effect.
    wr_rd(3'd1, 10'h0F0, 3'd0, 4'd0, 10'b1111111111, 1'b1, 1'b0);
    check_status("split", 8);
    // Mode values above 1 behave as a normal read.
    rd(3'd0, 4'd5, 10'b1111111111, 1'b1, 1'b0);
    check_status("mode5", 8);
    rd(3'd1, 4'd15, 10'h0F0, 1'b1, 1'b0);
    check_status("mode15", 8);

    // Idle cycle: q_a holds, strobes drop.
    cycle(1'b0, '0, '0, 1'b0, '0, 4'd0);
    check("idle q_a hold",   32'(q_a),          32'h0F0);
    check("idle valid_q",    32'(valid_q),      32'd0);
    check("idle err",        32'(err_rd_empty), 32'd0);

    // Reset together with a write: the write is discarded.
    reset = 1'b1;
    cycle(1'b1, 3'd2, 10'h155, 1'b0, '0, 4'd0);
    check_status("mid_rst", 0);
    check("mid_rst q_a", 32'(q_a), 32'd0);
    reset = 1'b0;
    rd(3'd2, 4'd0, 10'h000, 1'b0, 1'b1);
    check_status("post_rst", 0);
    wr(3'd3, 10'h123);
    check_status("post_rst_wr", 1);
    rd(3'd3, 4'd0, 10'h123, 1'b1, 1'b0);

    // Let the monitor drain, then every expected response must be consumed.
    repeat (3) @(posedge clk);
    check("scoreboard drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
